// File: rtl/pipe_incr_checker.sv
// pipe_incr_checker: receiving end of the incrementer chain.
// Takes (x, y, z) taps, recovers the original value as x-1, flags beats whose
// taps are not a consecutive +1 chain, and keeps saturating error statistics.
// Two register stages (S1 capture, S2 output) with a valid/ready stream on both
// sides; S1 can advance in the same cycle that S2 drains, so a full pipe still
// sustains one beat per clock.
module pipe_incr_checker #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [WIDTH-1:0]     z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky
);

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Chain consistency: y must be x+1 and z must be x+2, modulo 2^WIDTH.
  function automatic logic chain_err(input logic [WIDTH-1:0] tx,
                                     input logic [WIDTH-1:0] ty,
                                     input logic [WIDTH-1:0] tz);
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    x1 = tx + WIDTH'(1);
    x2 = tx + WIDTH'(2);
    return (ty != x1) || (tz != x2);
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_x_q, s1_x_d;
  logic [WIDTH-1:0]     s1_y_q, s1_y_d;
  logic [WIDTH-1:0]     s1_z_q, s1_z_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 err_sticky_q, err_sticky_d;

  logic s1_adv;
  logic accept;
  logic deliver;

  // Handshake decode: S1 moves into S2 whenever S2 is empty or draining.
  always_comb begin
    s1_adv  = s1_valid_q && (!out_valid_q || out_ready);
    deliver = out_valid_q && out_ready;
    accept  = in_valid && (!s1_valid_q || s1_adv);
  end

  assign in_ready   = !s1_valid_q || s1_adv;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

  // Next-state for both stages and the error statistics.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    s1_z_d       = s1_z_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;

    // S1 capture: taps stored unmodified
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = x;
      s1_y_d     = y;
      s1_z_d     = z;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2 output: recovered value and consistency flag; held while stalled
    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = s1_x_q - WIDTH'(1);
      out_err_d   = chain_err(s1_x_q, s1_y_q, s1_z_q);
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end

    if (deliver && out_err_q) begin
      err_count_d  = sat_inc(err_count_q);
      err_sticky_d = 1'b1;
    end
  end

  // Control and visible outputs: reset clears everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // S1 tap storage: meaningful only while s1_valid_q is set, so no reset.
  always_ff @(posedge clk) begin
    s1_x_q <= s1_x_d;
    s1_y_q <= s1_y_d;
    s1_z_q <= s1_z_d;
  end

endmodule

// File: tb/tb_pipe_incr_checker.sv
// Directed bench for pipe_incr_checker (WIDTH=8, ERR_CNT_W=2 so saturation is reachable).
module tb_pipe_incr_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x, y, z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic [1:0] err_count;
  logic       err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_incr_checker #(.WIDTH(8), .ERR_CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_count (err_count),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = 8'h00; y = 8'h00; z = 8'h00;
    step(); step();
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky: got %b expected 0", err_sticky); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; x = 8'h05; y = 8'h06; z = 8'h07; out_ready = 1'b1;
    step();
    in_valid = 1'b0; x = 8'hxx; y = 8'hxx; z = 8'hxx;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: out_valid got %b expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== 8'h04) begin n_fail++; $display("FAIL basic_data: got %h expected 04", out_data); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", out_err); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: out_valid got %b expected 0", out_valid); end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL basic_err_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_wrap();
    logic [7:0] tx [3] = '{8'h00, 8'hFE, 8'hFF};
    logic [7:0] ty [3] = '{8'h01, 8'hFF, 8'h00};
    logic [7:0] tz [3] = '{8'h02, 8'h00, 8'h01};
    logic [7:0] ex [3] = '{8'hFF, 8'hFD, 8'hFE};
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin in_valid = 1'b1; x = tx[c]; y = ty[c]; z = tz[c]; end
      else in_valid = 1'b0;
      #1;
      if (c < 3) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_in_ready c%0d: got %b expected 1", c, in_ready); end
      end
      if (out_valid === 1'b1) begin
        if (got < 3) begin
          n_checks++; if (out_data !== ex[got]) begin n_fail++; $display("FAIL wrap_data beat%0d: got %h expected %h", got, out_data, ex[got]); end
          n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err beat%0d: got %b expected 0", got, out_err); end
        end
        got++;
      end
      step();
    end
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL wrap_beat_count: got %0d expected 3", got); end
  endtask

  task automatic test_mismatch();
    logic [7:0] tx [2] = '{8'h10, 8'h20};
    logic [7:0] ty [2] = '{8'h12, 8'h21};
    logic [7:0] tz [2] = '{8'h13, 8'h23};
    logic [7:0] ex [2] = '{8'h0F, 8'h1F};
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 2) begin in_valid = 1'b1; x = tx[c]; y = ty[c]; z = tz[c]; end
      else in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        if (got < 2) begin
          n_checks++; if (out_data !== ex[got]) begin n_fail++; $display("FAIL mismatch_data beat%0d: got %h expected %h", got, out_data, ex[got]); end
          n_checks++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL mismatch_err beat%0d: got %b expected 1", got, out_err); end
        end
        got++;
      end
      step();
    end
    n_checks++; if (got != 2) begin n_fail++; $display("FAIL mismatch_beat_count: got %0d expected 2", got); end
    n_checks++; if (err_count !== 2'd2) begin n_fail++; $display("FAIL mismatch_err_count: got %0d expected 2", err_count); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky: got %b expected 1", err_sticky); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    logic have_hold = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic acc;
    logic exp_rdy;
    for (int c = 0; c < 30 && recv < 6; c++) begin
      out_ready = (c >= 5);
      if (sent < 6) begin
        in_valid = 1'b1;
        x = 8'(8'h50 + sent);
        y = 8'(8'h51 + sent);
        z = 8'(8'h52 + sent);
      end else in_valid = 1'b0;
      #1;
      exp_rdy = out_ready || (sent < 2);
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy); end
      if (have_hold) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== hold_d) begin n_fail++; $display("FAIL bp_stall_hold c%0d: got v%b %h expected v1 %h", c, out_valid, out_data, hold_d); end
      end
      have_hold = (out_valid === 1'b1) && !out_ready;
      hold_d = out_data;
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++; if (out_data !== 8'(8'h4F + recv)) begin n_fail++; $display("FAIL bp_order beat%0d: got %h expected %h", recv, out_data, 8'(8'h4F + recv)); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL bp_err beat%0d: got %b expected 0", recv, out_err); end
        recv++;
      end
      acc = in_valid && (in_ready === 1'b1);
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (recv != 6) begin n_fail++; $display("FAIL bp_recv_count: got %0d expected 6", recv); end
    n_checks++; if (sent != 6) begin n_fail++; $display("FAIL bp_sent_count: got %0d expected 6", sent); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x = 8'(8'h60 + i); y = 8'(8'h65 + i); z = 8'(8'h62 + i);
      step();
      in_valid = 1'b0;
      step();
      n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin n_fail++; $display("FAIL sat_beat_err%0d: got v%b e%b expected v1 e1", i, out_valid, out_err); end
      step();
      n_checks++; if (err_count !== ec[i]) begin n_fail++; $display("FAIL sat_count%0d: got %0d expected %0d", i, err_count, ec[i]); end
      n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky%0d: got %b expected 1", i, err_sticky); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; x = 8'h30; y = 8'h31; z = 8'h32;
    step();
    x = 8'h34; y = 8'h35; z = 8'h36;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || err_count !== 2'd3) begin n_fail++; $display("FAIL rmid_pre: got v%b cnt%0d expected v1 cnt3", out_valid, err_count); end
    reset = 1'b1; in_valid = 1'b1; x = 8'h41; y = 8'h42; z = 8'h43; out_ready = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL rmid_err_count: got %0d expected 0", err_count); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL rmid_sticky: got %b expected 0", err_sticky); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; x = 8'h41; y = 8'h42; z = 8'h43;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flushed: out_valid got %b expected 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin n_fail++; $display("FAIL rmid_next_beat: got v%b %h expected v1 40", out_valid, out_data); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rmid_next_err: got %b expected 0", out_err); end
    step();
    n_checks++; if (out_valid !== 1'b0 || err_count !== 2'd0) begin n_fail++; $display("FAIL rmid_drain: got v%b cnt%0d expected v0 cnt0", out_valid, err_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_mismatch();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
